// File: rtl/matmul_operand_loader.sv
// Buffers matrix A and matrix B from a host valid/ready stream, then replays them
// to the 3-lane multiplier as one (A, B) element pair per clock.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for load_start; in_ready low
// ST_LOAD   | accepting A/B elements in any interleaving until both full
// ST_STREAM | k = 0..N-1, one registered element pair per cycle
// ST_DONE   | one cycle; stream_done is registered out on the way to IDLE
module matmul_operand_loader #(
    parameter int P  = 3,
    parameter int Q  = 3,
    parameter int R  = 3,
    parameter int S  = 3,
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic          in_sel,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] A_val,
    output logic [AW-1:0] A_loc,
    output logic [DW-1:0] B_val,
    output logic [AW-1:0] B_loc,
    output logic          mat_valid,
    output logic          stream_done,
    output logic          busy
);

    localparam int NA  = P * Q;
    localparam int NB  = R * S;
    localparam int NN  = (NA > NB) ? NA : NB;
    localparam int AIW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [AW:0]   NA_W    = (AW + 1)'(NA);
    localparam logic [AW:0]   NB_W    = (AW + 1)'(NB);
    localparam logic [AW:0]   NN_LAST = (AW + 1)'(NN - 1);
    localparam logic [AW:0]   ONE_W   = (AW + 1)'(1);
    localparam logic [AW-1:0] A_LAST  = AW'(NA - 1);
    localparam logic [AW-1:0] B_LAST  = AW'(NB - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   a_cnt_q, a_cnt_d;
    logic [AW:0]   b_cnt_q, b_cnt_d;
    logic [AW:0]   k_q, k_d;
    logic [DW-1:0] a_val_q, a_val_d;
    logic [AW-1:0] a_loc_q, a_loc_d;
    logic [DW-1:0] b_val_q, b_val_d;
    logic [AW-1:0] b_loc_q, b_loc_d;
    logic          mat_valid_q, mat_valid_d;
    logic          stream_done_q, stream_done_d;

    logic [DW-1:0] buf_a_q [NA];
    logic [DW-1:0] buf_b_q [NB];

    logic          a_we, b_we, hs;
    logic [AW-1:0] a_loc_nxt, b_loc_nxt;

    assign in_ready = (state_q == ST_LOAD) &&
                      (in_sel ? (b_cnt_q < NB_W) : (a_cnt_q < NA_W));
    assign hs   = in_valid && in_ready && !clear;
    assign a_we = hs && !in_sel;
    assign b_we = hs && in_sel;

    // The shorter matrix keeps re-driving its last element until the longer one finishes.
    assign a_loc_nxt = (k_q < NA_W) ? k_q[AW-1:0] : A_LAST;
    assign b_loc_nxt = (k_q < NB_W) ? k_q[AW-1:0] : B_LAST;

    always_comb begin
        state_d       = state_q;
        a_cnt_d       = a_cnt_q;
        b_cnt_d       = b_cnt_q;
        k_d           = k_q;
        a_val_d       = a_val_q;
        a_loc_d       = a_loc_q;
        b_val_d       = b_val_q;
        b_loc_d       = b_loc_q;
        mat_valid_d   = 1'b0;
        stream_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    a_cnt_d = '0;
                    b_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if ((a_cnt_q == NA_W) && (b_cnt_q == NB_W)) begin
                    state_d = ST_STREAM;
                    k_d     = '0;
                end else begin
                    if (a_we) a_cnt_d = a_cnt_q + ONE_W;
                    if (b_we) b_cnt_d = b_cnt_q + ONE_W;
                end
            end
            ST_STREAM: begin
                mat_valid_d = 1'b1;
                a_loc_d     = a_loc_nxt;
                a_val_d     = buf_a_q[a_loc_nxt[AIW-1:0]];
                b_loc_d     = b_loc_nxt;
                b_val_d     = buf_b_q[b_loc_nxt[BIW-1:0]];
                if (k_q == NN_LAST) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + ONE_W;
                end
            end
            ST_DONE: begin
                stream_done_d = 1'b1;
                state_d       = ST_IDLE;
                a_cnt_d       = '0;
                b_cnt_d       = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d       = ST_IDLE;
            a_cnt_d       = '0;
            b_cnt_d       = '0;
            k_d           = '0;
            a_val_d       = '0;
            a_loc_d       = '0;
            b_val_d       = '0;
            b_loc_d       = '0;
            mat_valid_d   = 1'b0;
            stream_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_cnt_q       <= '0;
            b_cnt_q       <= '0;
            k_q           <= '0;
            a_val_q       <= '0;
            a_loc_q       <= '0;
            b_val_q       <= '0;
            b_loc_q       <= '0;
            mat_valid_q   <= 1'b0;
            stream_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_cnt_q       <= a_cnt_d;
            b_cnt_q       <= b_cnt_d;
            k_q           <= k_d;
            a_val_q       <= a_val_d;
            a_loc_q       <= a_loc_d;
            b_val_q       <= b_val_d;
            b_loc_q       <= b_loc_d;
            mat_valid_q   <= mat_valid_d;
            stream_done_q <= stream_done_d;
        end
    end

    // Buffer contents need no reset: every entry is rewritten before it is streamed.
    always_ff @(posedge clk) begin
        if (a_we) buf_a_q[a_cnt_q[AIW-1:0]] <= in_data;
        if (b_we) buf_b_q[b_cnt_q[BIW-1:0]] <= in_data;
    end

    assign A_val       = a_val_q;
    assign A_loc       = a_loc_q;
    assign B_val       = b_val_q;
    assign B_loc       = b_loc_q;
    assign mat_valid   = mat_valid_q;
    assign stream_done = stream_done_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Bench for matmul_operand_loader: a 3x3 instance and a 2x3-by-3x3 instance checked
// every cycle against a timeline model, plus literal pins on the directed scenarios.
module tb_matmul_operand_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]      clr = '0, ls = '0, iv = '0, isel = '0;
    logic [1:0][7:0] idat = '0;
    logic [1:0]      ir, mv, sd, bsy;
    logic [1:0][7:0] aval, aloc, bval, bloc;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    matmul_operand_loader #(.P(3), .Q(3), .R(3), .S(3), .DW(8), .AW(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .load_start(ls[0]),
        .in_valid(iv[0]), .in_sel(isel[0]), .in_data(idat[0]), .in_ready(ir[0]),
        .A_val(aval[0]), .A_loc(aloc[0]), .B_val(bval[0]), .B_loc(bloc[0]),
        .mat_valid(mv[0]), .stream_done(sd[0]), .busy(bsy[0])
    );

    matmul_operand_loader #(.P(2), .Q(3), .R(3), .S(3), .DW(8), .AW(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]), .load_start(ls[1]),
        .in_valid(iv[1]), .in_sel(isel[1]), .in_data(idat[1]), .in_ready(ir[1]),
        .A_val(aval[1]), .A_loc(aloc[1]), .B_val(bval[1]), .B_loc(bloc[1]),
        .mat_valid(mv[1]), .stream_done(sd[1]), .busy(bsy[1])
    );

    // Model: element lists plus the edge index at which both matrices became full.
    // Relative to that edge j: pair j-2 is on the outputs for j=2..N+1, done pulse at N+2,
    // busy through j=N, and a new load_start is honoured from j=N+3 on.
    int m_na[2] = '{9, 6};
    int m_nb[2] = '{9, 9};
    bit m_loading[2];
    int m_acnt[2], m_bcnt[2];
    int m_fill[2] = '{-1, -1};
    int m_aval[2], m_aloc[2], m_bval[2], m_bloc[2];
    int m_bufa[2][16];
    int m_bufb[2][16];

    function automatic int nmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic mdl_zero(input int i);
        m_loading[i] = 1'b0;
        m_acnt[i] = 0; m_bcnt[i] = 0; m_fill[i] = -1;
        m_aval[i] = 0; m_aloc[i] = 0; m_bval[i] = 0; m_bloc[i] = 0;
    endtask

    task automatic mdl_step(input int i);
        int na, nb, nn, j, k;
        na = m_na[i]; nb = m_nb[i]; nn = nmax(na, nb);
        j = cyc - m_fill[i];
        if (clr[i]) begin
            mdl_zero(i);
        end else begin
            if (m_fill[i] >= 0 && j >= 2 && j <= nn + 1) begin
                k = j - 2;
                m_aloc[i] = (k < na) ? k : na - 1;
                m_bloc[i] = (k < nb) ? k : nb - 1;
                m_aval[i] = m_bufa[i][m_aloc[i]];
                m_bval[i] = m_bufb[i][m_bloc[i]];
            end
            if (!m_loading[i] && (m_fill[i] < 0 || j >= nn + 3)) begin
                if (ls[i]) begin
                    m_loading[i] = 1'b1;
                    m_acnt[i] = 0; m_bcnt[i] = 0; m_fill[i] = -1;
                end
            end else if (m_loading[i] && iv[i]) begin
                if (!isel[i] && m_acnt[i] < na) begin
                    m_bufa[i][m_acnt[i]] = int'(idat[i]);
                    m_acnt[i]++;
                end else if (isel[i] && m_bcnt[i] < nb) begin
                    m_bufb[i][m_bcnt[i]] = int'(idat[i]);
                    m_bcnt[i]++;
                end
                if (m_acnt[i] == na && m_bcnt[i] == nb) begin
                    m_loading[i] = 1'b0;
                    m_fill[i] = cyc;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mdl_zero(i);
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) mdl_step(i);
        end
    end

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, want %0h", nm, inst, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int j, nn;
            bit e_mv, e_sd, e_busy, e_ir;
            nn = nmax(m_na[i], m_nb[i]);
            j = cyc - m_fill[i];
            e_mv   = (m_fill[i] >= 0) && (j >= 2) && (j <= nn + 1);
            e_sd   = (m_fill[i] >= 0) && (j == nn + 2);
            e_busy = m_loading[i] || ((m_fill[i] >= 0) && (j <= nn));
            e_ir   = m_loading[i] && (isel[i] ? (m_bcnt[i] < m_nb[i]) : (m_acnt[i] < m_na[i]));
            check("mat_valid", i, 32'(mv[i]), 32'(e_mv));
            check("stream_done", i, 32'(sd[i]), 32'(e_sd));
            check("busy", i, 32'(bsy[i]), 32'(e_busy));
            check("in_ready", i, 32'(ir[i]), 32'(e_ir));
            check("A_val", i, 32'(aval[i]), m_aval[i]);
            check("A_loc", i, 32'(aloc[i]), m_aloc[i]);
            check("B_val", i, 32'(bval[i]), m_bval[i]);
            check("B_loc", i, 32'(bloc[i]), m_bloc[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ls(input int inst);
        ls[inst] = 1'b1;
        tick();
        ls[inst] = 1'b0;
    endtask

    task automatic push(input int inst, input bit s, input logic [7:0] d, input int gap);
        bit ok, r;
        ok = 1'b0;
        repeat (gap) tick();
        iv[inst] = 1'b1; isel[inst] = s; idat[inst] = d;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            r = ir[inst];
            tick();
            ok = r;
        end
        iv[inst] = 1'b0;
        check("push_accepted", inst, 32'(ok), 32'd1);
    endtask

    // A data is 1..na (or random), B data is the 3x3 identity (or random).
    task automatic load_mat(input int inst, input int na, input int nb, input bit rnd_data,
                            input bit rnd_order, input bit stray_ls);
        int ai, bi, g;
        bit s;
        logic [7:0] d;
        ai = 0; bi = 0;
        while (ai < na || bi < nb) begin
            if (ai < na && bi < nb) s = rnd_order ? 1'($urandom_range(0, 1)) : 1'b0;
            else s = (ai >= na);
            g = rnd_order ? int'($urandom_range(0, 2)) : 0;
            if (!s) begin
                d = rnd_data ? 8'($urandom) : 8'(ai + 1);
                ai++;
            end else begin
                d = rnd_data ? 8'($urandom) : ((bi % 4 == 0) ? 8'd1 : 8'd0);
                bi++;
            end
            if (stray_ls && ai + bi == 5) pulse_ls(inst);
            push(inst, s, d, g);
        end
    endtask

    // Literal pins on a stream that follows a load_mat of sequential A data.
    task automatic check_stream(input int inst, input int na, input bit b_id);
        int k, done_n, done_at, last_v, eloc;
        k = 0; done_n = 0; done_at = -1; last_v = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mv[inst]) begin
                eloc = (k < na) ? k : na - 1;
                check("lit_A_loc", inst, 32'(aloc[inst]), eloc);
                check("lit_A_val", inst, 32'(aval[inst]), eloc + 1);
                check("lit_B_loc", inst, 32'(bloc[inst]), k);
                if (b_id) check("lit_B_val", inst, 32'(bval[inst]), (k % 4 == 0) ? 1 : 0);
                k++;
                last_v = t;
            end
            if (sd[inst]) begin
                done_n++;
                done_at = t;
            end
            if (done_n > 0 && t >= done_at + 2) break;
        end
        check("lit_pairs", inst, k, 9);
        check("lit_done_count", inst, done_n, 1);
        check("lit_done_pos", inst, done_at, last_v + 1);
        tick();
    endtask

    task automatic wait_done(input int inst);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            if (sd[inst]) seen = 1'b1;
        end
        check("done_seen", inst, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1);
    end

    initial begin
        int c0, nsd;
        bit found;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_A_val", 0, 32'(aval[0]), 0);
        check("rst_A_loc", 0, 32'(aloc[0]), 0);
        check("rst_B_val", 0, 32'(bval[0]), 0);
        check("rst_B_loc", 0, 32'(bloc[0]), 0);
        check("rst_mat_valid", 0, 32'(mv[0]), 0);
        check("rst_stream_done", 0, 32'(sd[0]), 0);
        check("rst_busy", 0, 32'(bsy[0]), 0);
        check("rst_in_ready", 0, 32'(ir[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Sequential 3x3 load: 18 back-to-back accepts, then the identity stream.
        pulse_ls(0);
        c0 = cyc;
        load_mat(0, 9, 9, 1'b0, 1'b0, 1'b0);
        check("seq_load_cycles", 0, cyc - c0, 18);
        check_stream(0, 9, 1'b1);

        // Interleaved with gaps and a stray load_start mid-load.
        pulse_ls(0);
        load_mat(0, 9, 9, 1'b0, 1'b1, 1'b1);
        check_stream(0, 9, 1'b1);

        // A full: further A elements back-pressured while B stays ready.
        pulse_ls(0);
        for (int i = 0; i < 9; i++) push(0, 1'b0, 8'(i + 1), 0);
        iv[0] = 1'b1; isel[0] = 1'b0; idat[0] = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("full_A_ready", 0, 32'(ir[0]), 0);
        end
        tick();
        iv[0] = 1'b0; isel[0] = 1'b1;
        @(negedge clk);
        check("B_ready_A_full", 0, 32'(ir[0]), 1);
        tick();
        for (int i = 0; i < 9; i++) push(0, 1'b1, (i % 4 == 0) ? 8'd1 : 8'd0, 0);
        check_stream(0, 9, 1'b1);

        // 2x3 A against 3x3 B: A_loc holds at 5 for the last three pairs.
        pulse_ls(1);
        load_mat(1, 6, 9, 1'b0, 1'b1, 1'b0);
        check_stream(1, 6, 1'b1);

        // clear while the stream is at k=4.
        pulse_ls(0);
        load_mat(0, 9, 9, 1'b1, 1'b1, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (mv[0] && aloc[0] == 8'd3) found = 1'b1;
        end
        check("clr_point_found", 0, 32'(found), 32'd1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        check("clr_mat_valid", 0, 32'(mv[0]), 0);
        check("clr_busy", 0, 32'(bsy[0]), 0);
        check("clr_A_loc", 0, 32'(aloc[0]), 0);
        check("clr_B_val", 0, 32'(bval[0]), 0);
        nsd = 0;
        repeat (15) begin
            @(negedge clk);
            if (sd[0]) nsd++;
        end
        check("clr_no_done", 0, nsd, 0);
        tick();
        pulse_ls(0);
        load_mat(0, 9, 9, 1'b0, 1'b0, 1'b0);
        check_stream(0, 9, 1'b1);

        // Asynchronous reset with five A elements loaded.
        pulse_ls(0);
        for (int i = 0; i < 5; i++) push(0, 1'b0, 8'(i + 1), 0);
        isel[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 0, 32'(bsy[0]), 0);
        check("arst_in_ready", 0, 32'(ir[0]), 0);
        check("arst_mat_valid", 0, 32'(mv[0]), 0);
        check("arst_stream_done", 0, 32'(sd[0]), 0);
        check("arst_A_val", 0, 32'(aval[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        iv[0] = 1'b1; isel[0] = 1'b0; idat[0] = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_load", 0, 32'(ir[0]), 0);
        end
        tick();
        iv[0] = 1'b0;
        pulse_ls(0);
        load_mat(0, 9, 9, 1'b0, 1'b0, 1'b0);
        check_stream(0, 9, 1'b1);

        // Random data and ordering on both instances.
        for (int it = 0; it < 6; it++) begin
            int inst;
            inst = it % 2;
            pulse_ls(inst);
            load_mat(inst, m_na[inst], 9, 1'b1, 1'b1, 1'b0);
            wait_done(inst);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
